// File: rtl/ps2_scancode_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_scancode_decoder
//  Description : Converts PS/2 set-2 scan-code bytes into strobed ASCII
//                character events. Break (0xF0), extended (0xE0) and
//                typematic-repeat sequences are stripped. Shift state from
//                either shift key is tracked.
//
//  Ports
//    clk                     in   system clock, rising edge
//    rst_n                   in   asynchronous active-low reset
//    ps2_received_data[7:0]  in   scan-code byte, valid while strobe is high
//    ps2_received_data_strb  in   one-cycle pulse per received byte
//    ascii_data[7:0]         out  decoded character, held between strobes
//    ascii_data_strb         out  one-cycle pulse, ascii_data valid with it
//    unmapped_strb           out  one-cycle pulse for a make code with no map
//    shift_active            out  high while either shift key is held
//
//  Parameters
//    REPEAT_FILTER  1: suppress typematic repeats of the held key
//                   0: every make code emits
//
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_scancode_decoder #(
    parameter int REPEAT_FILTER = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ps2_received_data,
    input  logic       ps2_received_data_strb,
    output logic [7:0] ascii_data,
    output logic       ascii_data_strb,
    output logic       unmapped_strb,
    output logic       shift_active
);

    localparam logic [7:0] c_code_ext      = 8'hE0;
    localparam logic [7:0] c_code_break    = 8'hF0;
    localparam logic [7:0] c_code_lshift   = 8'h12;
    localparam logic [7:0] c_code_rshift   = 8'h59;
    localparam logic [7:0] c_code_kp_enter = 8'h5A;
    localparam logic [7:0] c_ascii_cr      = 8'h0D;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] ascii_data_q, ascii_data_d;
    logic       ascii_strb_q, ascii_strb_d;
    logic       unmapped_q, unmapped_d;
    logic       shift_q, shift_d;
    logic [7:0] held_key_q, held_key_d;
    logic       held_ext_q, held_ext_d;

    logic [8:0] w_map;          // {mapped, ascii}
    logic       w_is_shift;
    logic       w_is_response;
    logic       w_filter_on;

    // Set-2 make code to ASCII. Letters are always uppercase; only '/' and
    // '1' have distinct shifted glyphs.
    function automatic logic [8:0] map_code(input logic [7:0] code,
                                            input logic       shifted);
        logic [8:0] r;
        r = 9'h000;
        case (code)
            8'h1C: r = {1'b1, 8'h41};  // A
            8'h32: r = {1'b1, 8'h42};  // B
            8'h21: r = {1'b1, 8'h43};  // C
            8'h23: r = {1'b1, 8'h44};  // D
            8'h24: r = {1'b1, 8'h45};  // E
            8'h2B: r = {1'b1, 8'h46};  // F
            8'h34: r = {1'b1, 8'h47};  // G
            8'h33: r = {1'b1, 8'h48};  // H
            8'h43: r = {1'b1, 8'h49};  // I
            8'h3B: r = {1'b1, 8'h4A};  // J
            8'h42: r = {1'b1, 8'h4B};  // K
            8'h4B: r = {1'b1, 8'h4C};  // L
            8'h3A: r = {1'b1, 8'h4D};  // M
            8'h31: r = {1'b1, 8'h4E};  // N
            8'h44: r = {1'b1, 8'h4F};  // O
            8'h4D: r = {1'b1, 8'h50};  // P
            8'h15: r = {1'b1, 8'h51};  // Q
            8'h2D: r = {1'b1, 8'h52};  // R
            8'h1B: r = {1'b1, 8'h53};  // S
            8'h2C: r = {1'b1, 8'h54};  // T
            8'h3C: r = {1'b1, 8'h55};  // U
            8'h2A: r = {1'b1, 8'h56};  // V
            8'h1D: r = {1'b1, 8'h57};  // W
            8'h22: r = {1'b1, 8'h58};  // X
            8'h35: r = {1'b1, 8'h59};  // Y
            8'h1A: r = {1'b1, 8'h5A};  // Z
            8'h45: r = {1'b1, 8'h30};  // 0
            8'h16: r = shifted ? {1'b1, 8'h21} : {1'b1, 8'h31};  // ! / 1
            8'h1E: r = {1'b1, 8'h32};  // 2
            8'h26: r = {1'b1, 8'h33};  // 3
            8'h25: r = {1'b1, 8'h34};  // 4
            8'h2E: r = {1'b1, 8'h35};  // 5
            8'h36: r = {1'b1, 8'h36};  // 6
            8'h3D: r = {1'b1, 8'h37};  // 7
            8'h3E: r = {1'b1, 8'h38};  // 8
            8'h46: r = {1'b1, 8'h39};  // 9
            8'h29: r = {1'b1, 8'h20};  // space
            8'h5A: r = {1'b1, 8'h0D};  // enter
            8'h66: r = {1'b1, 8'h08};  // backspace
            8'h49: r = {1'b1, 8'h2E};  // .
            8'h41: r = {1'b1, 8'h2C};  // ,
            8'h4A: r = shifted ? {1'b1, 8'h3F} : {1'b1, 8'h2F};  // ? / /
            default: r = 9'h000;
        endcase
        return r;
    endfunction

    assign w_filter_on   = (REPEAT_FILTER != 0);
    assign w_map         = map_code(ps2_received_data, shift_q);
    assign w_is_shift    = (ps2_received_data == c_code_lshift) ||
                           (ps2_received_data == c_code_rshift);
    // Keyboard controller responses that must never produce any output.
    assign w_is_response = (ps2_received_data == 8'hAA) ||
                           (ps2_received_data == 8'hFA) ||
                           (ps2_received_data == 8'hFE) ||
                           (ps2_received_data == 8'hEE) ||
                           (ps2_received_data == 8'h00) ||
                           (ps2_received_data == 8'hFF);

    always_comb begin
        state_d      = state_q;
        ascii_data_d = ascii_data_q;
        ascii_strb_d = 1'b0;
        unmapped_d   = 1'b0;
        shift_d      = shift_q;
        held_key_d   = held_key_q;
        held_ext_d   = held_ext_q;

        if (ps2_received_data_strb) begin
            if (ps2_received_data == c_code_ext) begin
                state_d = ST_EXT;
            end else if (ps2_received_data == c_code_break) begin
                // A redundant 0xF0 in a break state leaves the state alone.
                if (state_q == ST_IDLE) begin
                    state_d = ST_BRK;
                end else if (state_q == ST_EXT) begin
                    state_d = ST_EXT_BRK;
                end
            end else begin
                state_d = ST_IDLE;
                case (state_q)
                    ST_IDLE: begin
                        if (w_is_shift) begin
                            shift_d = 1'b1;
                        end else if (w_is_response) begin
                            shift_d = shift_q;
                        end else if (w_map[8]) begin
                            if (!(w_filter_on && !held_ext_q &&
                                  held_key_q == ps2_received_data)) begin
                                ascii_data_d = w_map[7:0];
                                ascii_strb_d = 1'b1;
                                held_key_d   = ps2_received_data;
                                held_ext_d   = 1'b0;
                            end
                        end else begin
                            unmapped_d = 1'b1;
                        end
                    end
                    ST_BRK: begin
                        if (w_is_shift) begin
                            shift_d = 1'b0;
                        end
                        if (!held_ext_q && held_key_q == ps2_received_data) begin
                            held_key_d = 8'h00;
                            held_ext_d = 1'b0;
                        end
                    end
                    ST_EXT: begin
                        // Keypad enter is the only extended key with a mapping.
                        if (ps2_received_data == c_code_kp_enter) begin
                            if (!(w_filter_on && held_ext_q &&
                                  held_key_q == c_code_kp_enter)) begin
                                ascii_data_d = c_ascii_cr;
                                ascii_strb_d = 1'b1;
                                held_key_d   = c_code_kp_enter;
                                held_ext_d   = 1'b1;
                            end
                        end
                    end
                    ST_EXT_BRK: begin
                        if (held_ext_q && held_key_q == ps2_received_data) begin
                            held_key_d = 8'h00;
                            held_ext_d = 1'b0;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ascii_data_q <= 8'h00;
            ascii_strb_q <= 1'b0;
            unmapped_q   <= 1'b0;
            shift_q      <= 1'b0;
            held_key_q   <= 8'h00;
            held_ext_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ascii_data_q <= ascii_data_d;
            ascii_strb_q <= ascii_strb_d;
            unmapped_q   <= unmapped_d;
            shift_q      <= shift_d;
            held_key_q   <= held_key_d;
            held_ext_q   <= held_ext_d;
        end
    end

    assign ascii_data      = ascii_data_q;
    assign ascii_data_strb = ascii_strb_q;
    assign unmapped_strb   = unmapped_q;
    assign shift_active    = shift_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_scancode_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_scancode_decoder
//  Description : Directed self-checking bench for ps2_scancode_decoder.
//                A second instance with the repeat filter disabled shares
//                the same stimulus; its output pulses are counted.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ps2_scancode_decoder;

    logic       clk;
    logic       rst_n;
    logic [7:0] ps2_received_data;
    logic       ps2_received_data_strb;

    logic [7:0] ascii_data;
    logic       ascii_data_strb;
    logic       unmapped_strb;
    logic       shift_active;

    logic [7:0] nf_ascii_data;
    logic       nf_ascii_data_strb;
    logic       nf_unmapped_strb;
    logic       nf_shift_active;

    int n_cmp;
    int n_bad;
    int nf_pulses;
    int nf_base;

    ps2_scancode_decoder #(.REPEAT_FILTER(1)) u_dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .ps2_received_data      (ps2_received_data),
        .ps2_received_data_strb (ps2_received_data_strb),
        .ascii_data             (ascii_data),
        .ascii_data_strb        (ascii_data_strb),
        .unmapped_strb          (unmapped_strb),
        .shift_active           (shift_active)
    );

    ps2_scancode_decoder #(.REPEAT_FILTER(0)) u_dut_nf (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .ps2_received_data      (ps2_received_data),
        .ps2_received_data_strb (ps2_received_data_strb),
        .ascii_data             (nf_ascii_data),
        .ascii_data_strb        (nf_ascii_data_strb),
        .unmapped_strb          (nf_unmapped_strb),
        .shift_active           (nf_shift_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) nf_pulses <= 0;
        else if (nf_ascii_data_strb) nf_pulses <= nf_pulses + 1;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one strobed byte at a falling edge; on return the registered
    // result of that byte is visible. Consecutive calls give back-to-back strobes.
    task automatic drv(input logic [7:0] b);
        ps2_received_data      = b;
        ps2_received_data_strb = 1'b1;
        @(negedge clk);
        ps2_received_data_strb = 1'b0;
    endtask

    // {ascii_strb, unmapped_strb, ascii_data}
    function automatic logic [15:0] outs();
        return {6'd0, ascii_data_strb, unmapped_strb, ascii_data};
    endfunction

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        ps2_received_data      = 8'h00;
        ps2_received_data_strb = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs",  outs(), 16'h0000);
        chk("reset_shift", {15'd0, shift_active}, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);

        // Make, break of A: one pulse only
        drv(8'h1C); chk("a_make",  outs(), 16'h0241);
        drv(8'hF0); chk("a_f0",    outs(), 16'h0041);
        drv(8'h1C); chk("a_break", outs(), 16'h0041);

        // Data without strobe is ignored
        ps2_received_data = 8'h32;
        @(negedge clk);
        chk("no_strobe", outs(), 16'h0041);

        // Shift handling
        drv(8'h12); chk("lshift_on", {15'd0, shift_active}, 16'h0001);
        drv(8'h4A); chk("shift_slash", outs(), 16'h023F);
        drv(8'hF0);
        drv(8'h4A); chk("slash_break", outs(), 16'h003F);
        drv(8'hF0);
        drv(8'h12); chk("lshift_off", {15'd0, shift_active}, 16'h0000);
        drv(8'h4A); chk("slash_plain", outs(), 16'h022F);
        drv(8'hF0);
        drv(8'h4A);

        // Repeat filter: 24 x3, F0 24, 24
        @(negedge clk);
        nf_base = nf_pulses;
        drv(8'h24); chk("e_first",  outs(), 16'h0245);
        drv(8'h24); chk("e_rep1",   outs(), 16'h0045);
        drv(8'h24); chk("e_rep2",   outs(), 16'h0045);
        drv(8'hF0);
        drv(8'h24); chk("e_break",  outs(), 16'h0045);
        drv(8'h24); chk("e_again",  outs(), 16'h0245);
        @(negedge clk);
        chk("nofilter_count", 16'(nf_pulses - nf_base), 16'd4);

        // Extended sequences
        drv(8'hE0); chk("ext_prefix", outs(), 16'h0045);
        drv(8'h5A); chk("kp_enter",   outs(), 16'h020D);
        drv(8'hE0);
        drv(8'h75); chk("ext_up",     outs(), 16'h000D);
        drv(8'hE0);
        drv(8'hF0);
        drv(8'h75); chk("ext_up_brk", outs(), 16'h000D);
        drv(8'h1C); chk("idle_after_ext", outs(), 16'h0241);

        // Unmapped, response, space back-to-back
        drv(8'h0E); chk("unmapped",  outs(), 16'h0141);
        drv(8'hAA); chk("response",  outs(), 16'h0041);
        drv(8'h29); chk("space",     outs(), 16'h0220);

        // Reset mid-sequence with shift held
        drv(8'h59); chk("rshift_on", {15'd0, shift_active}, 16'h0001);
        drv(8'hF0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_outs",  outs(), 16'h0000);
        chk("async_rst_shift", {15'd0, shift_active}, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        chk("rst_hold_outs", outs(), 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);
        drv(8'h16); chk("one_after_rst", outs(), 16'h0231);

        // Shifted '1' gives '!'
        drv(8'hF0);
        drv(8'h16);
        drv(8'h59);
        drv(8'h16); chk("bang", outs(), 16'h0221);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Translates raw PS/2 keyboard scan-code bytes (set 2) into ASCII character events for the Morse path. It sits between the PS/2 receiver and the Morse data-control stage. It consumes the receiver's byte/strobe pair and produces one strobed ASCII byte per key press. Break, extended and typematic-repeat sequences are stripped, and shift state is tracked.

## Interface
Parameters:
- REPEAT_FILTER, default 1: when 1, typematic repeats of the held key are suppressed; when 0, every make code emits.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset. Reset is asserted asynchronously and deasserted on clk.
- ps2_received_data, input, 8: scan-code byte from the PS/2 receiver; valid only while strobe is high.
- ps2_received_data_strb, input, 1: one-cycle pulse per received byte. Pulses may arrive on consecutive cycles.
- ascii_data, output, 8: decoded ASCII character. Holds its last value between strobes.
- ascii_data_strb, output, 1: one-cycle pulse; ascii_data is valid in the same cycle.
- unmapped_strb, output, 1: one-cycle pulse for a make code with no mapping.
- shift_active, output, 1: level; high while either shift key is held.

## Operation
- FSM states:
  - IDLE: normal byte expected.
  - BRK: 0xF0 seen.
  - EXT: 0xE0 seen.
  - EXT_BRK: 0xE0 0xF0 seen.
- Transitions on a strobed byte:
  - 0xE0 in any state -> EXT.
  - 0xF0 in IDLE -> BRK.
  - 0xF0 in EXT -> EXT_BRK.
  - 0xF0 in BRK or EXT_BRK -> stays in the same state.
  - Any other byte is processed according to the current state, then the FSM goes to IDLE.
- IDLE, other byte:
  - 0x12 or 0x59 (L/R shift): set shift_active.
  - 0xAA, 0xFA, 0xFE, 0xEE, 0x00, 0xFF (controller responses): ignored, no output, no error.
  - Mapped make code: emit its ASCII value, subject to the repeat filter.
  - Anything else: pulse unmapped_strb.
- Map, unshifted:
  - 0x1C A, 0x32 B, 0x21 C, 0x23 D, 0x24 E, 0x2B F, 0x34 G, 0x33 H, 0x43 I.
  - 0x3B J, 0x42 K, 0x4B L, 0x3A M, 0x31 N, 0x44 O, 0x4D P, 0x15 Q, 0x2D R.
  - 0x1B S, 0x2C T, 0x3C U, 0x2A V, 0x1D W, 0x22 X, 0x35 Y, 0x1A Z.
  - 0x45 '0', 0x16 '1', 0x1E '2', 0x26 '3', 0x25 '4', 0x2E '5', 0x36 '6', 0x3D '7', 0x3E '8', 0x46 '9'.
  - 0x29 space 0x20, 0x5A enter 0x0D, 0x66 backspace 0x08, 0x49 '.', 0x41 ',', 0x4A '/'.
- Letters are always emitted as uppercase (0x41-0x5A), regardless of shift.
- Shift overrides: 0x4A -> '?' (0x3F), 0x16 -> '!' (0x21). Every other key emits its unshifted value when shifted.
- EXT, other byte: 0x5A (keypad enter) emits 0x0D. All other extended make codes are ignored silently.
- BRK, other byte:
  - 0x12 or 0x59 clears shift_active.
  - If the byte equals held_key, held_key is cleared to 0x00.
  - No output is produced.
- EXT_BRK, other byte: no output; if the byte equals {held_key tagged extended}, held_key is cleared.
- Repeat filter (REPEAT_FILTER=1):
  - held_key is an 8-bit register plus an extended flag.
  - A mapped make code identical to held_key (including the extended flag) emits nothing.
  - Otherwise the code emits and becomes the new held_key.
  - Shift keys never touch held_key.
- Unmapped make codes do not alter held_key.

## Timing
- Reset values: ascii_data=0x00, ascii_data_strb=0, unmapped_strb=0, shift_active=0, FSM=IDLE, held_key=0x00 with extended flag 0.
- Latency: ascii_data_strb and unmapped_strb pulse exactly 1 cycle after the input strobe. All outputs are registered.
- At most one output pulse per input strobe. ascii_data_strb and unmapped_strb are never high in the same cycle.
- Back-to-back input strobes on every cycle are processed without loss. Output strobes then also occur on consecutive cycles.
- shift_active updates 1 cycle after the strobe that carries the shift byte. A letter strobed on the cycle right after a shift byte already sees the updated shift.
- rst_n asserted mid-sequence (for example after 0xF0) returns the FSM to IDLE and clears all state. The next byte is treated as a fresh make code.
- Bytes presented without a strobe are ignored.

## Test plan
- Strobe 0x1C, then 0xF0, then 0x1C -> one ascii_data_strb with 0x41 one cycle after the first strobe; no further pulses.
- Strobe 0x12, then 0x4A, then 0xF0 0x4A, then 0xF0 0x12, then 0x4A -> outputs 0x3F then 0x2F. shift_active goes 1 after the first byte and 0 after the final 0x12.
- REPEAT_FILTER=1: strobe 0x24 three times, then 0xF0 0x24, then 0x24 -> exactly two outputs of 0x45. With REPEAT_FILTER=0 the same stimulus gives four outputs.
- Strobe 0xE0 0x5A, then 0xE0 0x75, then 0xE0 0xF0 0x75 -> one 0x0D output, no unmapped_strb. The FSM is IDLE at the end.
- Strobe 0x0E, then 0xAA, then 0x29 on consecutive cycles -> unmapped_strb pulse, then nothing, then 0x20 on ascii_data_strb. Each result appears 1 cycle after its strobe.
- Strobe 0xF0, assert rst_n low for 2 cycles, release, then strobe 0x16 -> output 0x31. All outputs read reset values while rst_n is low.
